iiitb_rv32i_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB). A shadow pipeline
//  of in-flight destinations detects RAW hazards at ID, and the block drives stall,

---
 rtl/iiitb_rv32i_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_iiitb_rv32i_hazard_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_rv32i_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: RAW detection against a
// shadow pipeline of in-flight destinations, branch flush, memory freeze, perf counters, watchdog.
module iiitb_rv32i_hazard_ctrl #(
   parameter int REG_AW    = 5,
   parameter int DEPTH     = 3,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 64
) (
   input  logic              clk,
   input  logic              RN,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_use_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wen,
   input  logic              ex_br_taken,
   input  logic              mem_busy,
   output logic              stall,
   output logic              bubble,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              hang_err
);

   localparam int RUN_W = $clog2(MAX_STALL + 1);

   typedef enum logic [1:0] {
      ACT_ISSUE  = 2'd0,
      ACT_HAZ    = 2'd1,
      ACT_FLUSH  = 2'd2,
      ACT_FREEZE = 2'd3
   } act_e;

   act_e                         act;
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0]             wen_q, wen_d;
   logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]             flush_cnt_q, flush_cnt_d;
   logic [RUN_W-1:0]             run_q, run_d;
   logic                         hang_q, hang_d;
   logic                         hit_rs1, hit_rs2, haz, stall_int;

   // The WB slot is included: the regfile write and the ID read share an edge.
   always_comb begin
      hit_rs1 = 1'b0;
      hit_rs2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && wen_q[i] && (rd_q[i] == id_rs1) && (id_rs1 != '0)) hit_rs1 = 1'b1;
         if (vld_q[i] && wen_q[i] && (rd_q[i] == id_rs2) && (id_rs2 != '0)) hit_rs2 = 1'b1;
      end
      haz = id_valid & ((id_use_rs1 & hit_rs1) | (id_use_rs2 & hit_rs2));
   end

   always_comb begin
      if (mem_busy)         act = ACT_FREEZE;
      else if (ex_br_taken) act = ACT_FLUSH;
      else if (haz)         act = ACT_HAZ;
      else                  act = ACT_ISSUE;
      stall_int = (act == ACT_FREEZE) || (act == ACT_HAZ);
   end

   // While in reset the pipeline is held with a NOP in ID/EX.
   always_comb begin
      stall  = 1'b0;
      bubble = 1'b1;
      flush  = 1'b0;
      if (RN) begin
         case (act)
            ACT_FREEZE: begin stall = 1'b1; bubble = 1'b0; end
            ACT_FLUSH:  begin flush = 1'b1; bubble = 1'b1; end
            ACT_HAZ:    begin stall = 1'b1; bubble = 1'b1; end
            default:    bubble = ~id_valid;
         endcase
      end
   end

   always_comb begin
      vld_d = vld_q;
      wen_d = wen_q;
      rd_d  = rd_q;
      if (act != ACT_FREEZE) begin
         for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            wen_d[i] = wen_q[i-1];
            rd_d[i]  = rd_q[i-1];
         end
         vld_d[0] = (act == ACT_ISSUE) && id_valid;
         wen_d[0] = id_wen;
         rd_d[0]  = id_rd;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      run_d       = '0;
      hang_d      = hang_q;
      if (stall_int) begin
         if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         run_d = (run_q == RUN_W'(MAX_STALL)) ? run_q : run_q + RUN_W'(1);
         if (run_d == RUN_W'(MAX_STALL)) hang_d = 1'b1;
      end
      if ((act == ACT_FLUSH) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         vld_q       <= '0;
         wen_q       <= '0;
         rd_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         run_q       <= '0;
         hang_q      <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         wen_q       <= wen_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= run_d;
         hang_q      <= hang_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign hang_err  = hang_q;

endmodule

// File: tb/tb_iiitb_rv32i_hazard_ctrl.sv
// Bench for iiitb_rv32i_hazard_ctrl: two instances (default and small CNT_W/MAX_STALL)
// share stimulus and are compared against a queue-style shadow-pipeline model.
module tb_iiitb_rv32i_hazard_ctrl;
   localparam int DEPTH = 3;

   logic       clk = 1'b0;
   logic       RN;
   logic       id_valid, id_use_rs1, id_use_rs2, id_wen, ex_br_taken, mem_busy;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic        st_a, bb_a, fl_a, hang_a, st_b, bb_b, fl_b, hang_b;
   logic [15:0] sc_a, fc_a;
   logic [3:0]  sc_b, fc_b;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   iiitb_rv32i_hazard_ctrl dut_a (
      .clk(clk), .RN(RN), .id_valid(id_valid), .id_rs1(id_rs1), .id_use_rs1(id_use_rs1),
      .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
      .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .stall(st_a), .bubble(bb_a),
      .flush(fl_a), .stall_cnt(sc_a), .flush_cnt(fc_a), .hang_err(hang_a));

   iiitb_rv32i_hazard_ctrl #(.CNT_W(4), .MAX_STALL(4)) dut_b (
      .clk(clk), .RN(RN), .id_valid(id_valid), .id_rs1(id_rs1), .id_use_rs1(id_use_rs1),
      .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
      .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .stall(st_b), .bubble(bb_b),
      .flush(fl_b), .stall_cnt(sc_b), .flush_cnt(fc_b), .hang_err(hang_b));

   // Reference model: list of in-flight writers, plain integer counters.
   bit       mv[DEPTH];
   bit       mwen[DEPTH];
   bit [4:0] mrd[DEPTH];
   int       m_sc_a, m_fc_a, m_sc_b, m_fc_b, m_run;
   bit       m_hang_a, m_hang_b;

   function automatic bit m_writes(input logic [4:0] x);
      for (int i = 0; i < DEPTH; i++)
         if (mv[i] && mwen[i] && mrd[i] == x && x != 5'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_haz();
      return id_valid && ((id_use_rs1 && m_writes(id_rs1)) || (id_use_rs2 && m_writes(id_rs2)));
   endfunction

   // {stall, bubble, flush}
   function automatic logic [2:0] m_out();
      if (!RN)              return 3'b010;
      else if (mem_busy)    return 3'b100;
      else if (ex_br_taken) return 3'b011;
      else if (m_haz())     return 3'b110;
      else                  return {1'b0, !id_valid, 1'b0};
   endfunction

   function automatic logic [41:0] m_cnt();
      return {16'(m_sc_a), 16'(m_fc_a), m_hang_a, 4'(m_sc_b), 4'(m_fc_b), m_hang_b};
   endfunction

   function automatic logic [5:0] obs_out();
      return {st_a, bb_a, fl_a, st_b, bb_b, fl_b};
   endfunction

   function automatic logic [41:0] obs_cnt();
      return {sc_a, fc_a, hang_a, sc_b, fc_b, hang_b};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin mv[i] = 0; mwen[i] = 0; mrd[i] = 0; end
      m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0; m_run = 0;
      m_hang_a = 0; m_hang_b = 0;
   endtask

   task automatic m_clock();
      logic [2:0] o;
      bit         h;
      o = m_out();
      h = m_haz();
      if (!RN) m_reset();
      else begin
         if (!mem_busy) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
               mv[i] = mv[i-1]; mwen[i] = mwen[i-1]; mrd[i] = mrd[i-1];
            end
            mv[0]   = !ex_br_taken && !h && id_valid;
            mwen[0] = id_wen;
            mrd[0]  = id_rd;
         end
         if (o[2]) begin
            if (m_sc_a < 65535) m_sc_a++;
            if (m_sc_b < 15)    m_sc_b++;
            m_run++;
            if (m_run >= 64) m_hang_a = 1;
            if (m_run >= 4)  m_hang_b = 1;
         end else m_run = 0;
         if (!mem_busy && ex_br_taken) begin
            if (m_fc_a < 65535) m_fc_a++;
            if (m_fc_b < 15)    m_fc_b++;
         end
      end
   endtask

   task automatic set_in(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic w, input logic br, input logic busy);
      @(negedge clk);
      id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
      id_rd = rd; id_wen = w; ex_br_taken = br; mem_busy = busy;
   endtask

   task automatic step();
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
   endtask

   task automatic test_reset();
      RN = 1'b1;
      set_in(1, 3, 1, 4, 1, 5, 1, 1, 1);
      RN = 1'b0;
      m_reset();
      #1;
      tests_run++;
      if (obs_out() !== 6'b010_010) begin
         tests_failed++;
         $display("FAIL reset_out: got %b want 010010", obs_out());
      end
      @(posedge clk); #1;
      tests_run++;
      if (obs_cnt() !== 42'd0 || obs_out() !== 6'b010_010) begin
         tests_failed++;
         $display("FAIL reset_state: cnt %h out %b want 0 / 010010", obs_cnt(), obs_out());
      end
      RN = 1'b1;
   endtask

   task automatic test_raw_stall();
      int nst = 0;
      int sc0;
      idle(3);
      sc0 = m_sc_a;
      set_in(1, 0, 0, 0, 0, 6, 1, 0, 0);
      #1; tests_run++;
      if (obs_out() !== 6'b000_000) begin
         tests_failed++;
         $display("FAIL raw_issue: got %b want 000000", obs_out());
      end
      step();
      for (int k = 0; k < 6; k++) begin
         logic st;
         set_in(1, 6, 1, 0, 0, 9, 0, 0, 0);
         #1; tests_run++;
         if (obs_out() !== {m_out(), m_out()}) begin
            tests_failed++;
            $display("FAIL raw_out cyc %0d: got %b want %b", k, obs_out(), {m_out(), m_out()});
         end
         st = st_a;
         if (st) nst++;
         step();
         tests_run++;
         if (obs_cnt() !== m_cnt()) begin
            tests_failed++;
            $display("FAIL raw_cnt cyc %0d: got %h want %h", k, obs_cnt(), m_cnt());
         end
         if (!st) break;
      end
      tests_run++;
      if (nst != 3 || sc_a !== 16'(sc0 + 3)) begin
         tests_failed++;
         $display("FAIL raw_len: stalls %0d stall_cnt %0d want 3 / %0d", nst, sc_a, sc0 + 3);
      end
   endtask

   task automatic test_x0();
      int sc0;
      idle(3);
      sc0 = m_sc_a;
      set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
      step();
      for (int k = 0; k < 3; k++) begin
         set_in(1, 0, 1, 0, 1, 2, 1, 0, 0);
         #1; tests_run++;
         if (st_a !== 1'b0 || obs_out() !== {m_out(), m_out()}) begin
            tests_failed++;
            $display("FAIL x0_out cyc %0d: got %b want %b", k, obs_out(), {m_out(), m_out()});
         end
         step();
      end
      tests_run++;
      if (sc_a !== 16'(sc0)) begin
         tests_failed++;
         $display("FAIL x0_cnt: stall_cnt %0d want %0d", sc_a, sc0);
      end
   endtask

   task automatic test_branch();
      int fc0;
      idle(3);
      fc0 = m_fc_a;
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
      step();
      set_in(1, 5, 1, 0, 0, 8, 1, 1, 0);
      #1; tests_run++;
      if (obs_out() !== 6'b011_011) begin
         tests_failed++;
         $display("FAIL br_out: got %b want 011011", obs_out());
      end
      step();
      tests_run++;
      if (fc_a !== 16'(fc0 + 1) || obs_cnt() !== m_cnt()) begin
         tests_failed++;
         $display("FAIL br_cnt: got %h want %h", obs_cnt(), m_cnt());
      end
   endtask

   task automatic test_freeze();
      int nst = 0;
      idle(3);
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0);
      step();
      for (int k = 0; k < 5; k++) begin
         set_in(1, 7, 1, 0, 0, 3, 1, k == 2, 1);
         #1; tests_run++;
         if (obs_out() !== 6'b100_100) begin
            tests_failed++;
            $display("FAIL frz_out cyc %0d: got %b want 100100", k, obs_out());
         end
         step();
      end
      for (int k = 0; k < 6; k++) begin
         logic st;
         set_in(1, 7, 1, 0, 0, 3, 1, 0, 0);
         #1; tests_run++;
         if (obs_out() !== {m_out(), m_out()}) begin
            tests_failed++;
            $display("FAIL frz_rel cyc %0d: got %b want %b", k, obs_out(), {m_out(), m_out()});
         end
         st = st_a;
         if (st) nst++;
         step();
         if (!st) break;
      end
      tests_run++;
      if (nst != 3 || obs_cnt() !== m_cnt()) begin
         tests_failed++;
         $display("FAIL frz_len: stalls %0d want 3, cnt %h want %h", nst, obs_cnt(), m_cnt());
      end
   endtask

   task automatic test_watchdog();
      @(negedge clk); #2 RN = 1'b0; #1 m_reset();
      @(posedge clk); #1 RN = 1'b1;
      idle(1);
      for (int k = 0; k < 4; k++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
         #1; tests_run++;
         if (obs_out() !== {m_out(), m_out()}) begin
            tests_failed++;
            $display("FAIL wd_out cyc %0d: got %b want %b", k, obs_out(), {m_out(), m_out()});
         end
         step();
         tests_run++;
         if (hang_b !== (k == 3) || obs_cnt() !== m_cnt()) begin
            tests_failed++;
            $display("FAIL wd_hang cyc %0d: got %h want %h", k, obs_cnt(), m_cnt());
         end
      end
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0);
      step();
      idle(1);
      tests_run++;
      if (hang_b !== 1'b1 || hang_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL wd_sticky: hang_b %b hang_a %b want 1 0", hang_b, hang_a);
      end
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0);
      step();
      @(negedge clk); #2 RN = 1'b0; #1;
      m_reset();
      tests_run++;
      if (obs_cnt() !== 42'd0 || obs_out() !== 6'b010_010) begin
         tests_failed++;
         $display("FAIL wd_clear: cnt %h out %b want 0 / 010010", obs_cnt(), obs_out());
      end
      @(posedge clk); #1 RN = 1'b1;
      set_in(1, 9, 1, 0, 0, 1, 0, 0, 0);
      #1; tests_run++;
      if (obs_out() !== 6'b000_000) begin
         tests_failed++;
         $display("FAIL wd_slots: got %b want 000000", obs_out());
      end
      step();
   endtask

   task automatic test_flush_sat();
      for (int k = 0; k < 20; k++) begin
         set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1, 0, 0, 5'($urandom_range(0, 7)), 1, 1, 0);
         #1; tests_run++;
         if (obs_out() !== 6'b011_011) begin
            tests_failed++;
            $display("FAIL fsat_out cyc %0d: got %b want 011011", k, obs_out());
         end
         step();
      end
      tests_run++;
      if (fc_b !== 4'd15 || fc_a !== 16'd20) begin
         tests_failed++;
         $display("FAIL fsat_cnt: fc_b %0d fc_a %0d want 15 20", fc_b, fc_a);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         id_valid    = $urandom_range(0, 9) < 8;
         id_rs1      = 5'($urandom_range(0, 7));
         id_use_rs1  = $urandom_range(0, 3) != 0;
         id_rs2      = 5'($urandom_range(0, 7));
         id_use_rs2  = $urandom_range(0, 1) != 0;
         id_rd       = 5'($urandom_range(0, 7));
         id_wen      = $urandom_range(0, 3) != 0;
         ex_br_taken = $urandom_range(0, 9) == 0;
         mem_busy    = (n % 100 > 90) || ($urandom_range(0, 7) == 0);
         #1; tests_run++;
         if (obs_out() !== {m_out(), m_out()}) begin
            tests_failed++;
            $display("FAIL rnd_out cyc %0d: got %b want %b", n, obs_out(), {m_out(), m_out()});
         end
         if ($urandom_range(0, 99) == 0) begin
            RN = 1'b0; #1;
            m_reset();
            tests_run++;
            if (obs_cnt() !== 42'd0 || obs_out() !== 6'b010_010) begin
               tests_failed++;
               $display("FAIL rnd_rst cyc %0d: cnt %h out %b", n, obs_cnt(), obs_out());
            end
            @(posedge clk); #1 RN = 1'b1;
         end else begin
            step();
            tests_run++;
            if (obs_cnt() !== m_cnt()) begin
               tests_failed++;
               $display("FAIL rnd_cnt cyc %0d: got %h want %h", n, obs_cnt(), m_cnt());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_raw_stall();
      test_x0();
      test_branch();
      test_freeze();
      test_watchdog();
      test_flush_sat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

endmodule
